// File: rtl/ifid_pkg.sv
// Shared types and constants for the IF/ID register and decode stage.
package ifid_pkg;

  localparam int DW = 16;
  localparam int RW = 3;

  typedef enum logic [4:0] {
    OP_HALT = 5'b00000,
    OP_NOP  = 5'b00001,
    OP_SIIC = 5'b00010,
    OP_RTI  = 5'b00011
  } opcode_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_EXC    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [DW-1:0] NOP_INST = 16'h0800;

  // Sign-extend the low 'bits' bits of v to the full datapath width.
  function automatic logic [DW-1:0] sext(input logic [DW-1:0] v, input int unsigned bits);
    logic signed [DW-1:0] t;
    t = $signed(v << (DW - bits));
    return $unsigned(t >>> (DW - bits));
  endfunction

endpackage

// File: rtl/ifid_exc_fsm.sv
// Exception/halt state tracking for the ID slot: registered fetch-redirect pulses
// and the flag that kills the one slot fetched while fetch was reacting to a pulse.
module ifid_exc_fsm
  import ifid_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_opcode,
  input  logic       id_err,
  input  logic       stall,
  input  logic       branch_taken,
  output state_t     state,
  output logic       illegal_pulse,
  output logic       return_pulse,
  output logic       squash,
  output logic       redirect
);

  state_t state_reg, state_next;
  logic   illegal_reg, illegal_next;
  logic   return_reg, return_next;
  logic   squash_reg;
  logic   fault;

  assign fault = (id_opcode == OP_SIIC) || id_err;

  // An older branch in execute or a stall both keep the ID instruction from acting.
  always_comb begin
    state_next   = state_reg;
    illegal_next = 1'b0;
    return_next  = 1'b0;
    if (id_valid && !stall && !branch_taken) begin
      case (state_reg)
        ST_RUN: begin
          if (fault) begin
            illegal_next = 1'b1;
            state_next   = ST_EXC;
          end else if (id_opcode == OP_HALT) begin
            state_next = ST_HALTED;
          end
        end
        ST_EXC: begin
          if (fault || id_opcode == OP_HALT) begin
            state_next = ST_HALTED;
          end else if (id_opcode == OP_RTI) begin
            return_next = 1'b1;
            state_next  = ST_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_RUN;
      illegal_reg <= 1'b0;
      return_reg  <= 1'b0;
      squash_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      illegal_reg <= illegal_next;
      return_reg  <= return_next;
      if (illegal_next || return_next) begin
        squash_reg <= 1'b1;
      end else if (!stall && !branch_taken) begin
        squash_reg <= 1'b0;
      end
    end
  end

  assign state         = state_reg;
  assign illegal_pulse = illegal_reg;
  assign return_pulse  = return_reg;
  assign squash        = squash_reg;
  assign redirect      = illegal_next || return_next;

endmodule

// File: rtl/ifid_decode.sv
// IF/ID pipeline register with field decode; exception/halt control lives in ifid_exc_fsm.
module ifid_decode
  import ifid_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] inst_ifid_p1,
  input  logic [DW-1:0] pc_p1,
  input  logic [DW-1:0] nxt_pc_p1,
  input  logic          err_p1,
  input  logic          stall_p1,
  input  logic          branch_taken_ixif_p1,
  output logic          illegal_op_idif_p1,
  output logic          return_execution_idif_p1,
  output logic          valid_idix_p1,
  output logic [DW-1:0] inst_idix_p1,
  output logic [DW-1:0] pc_idix_p1,
  output logic [DW-1:0] nxt_pc_idix_p1,
  output logic [4:0]    opcode_idix_p1,
  output logic [RW-1:0] rs_idix_p1,
  output logic [RW-1:0] rt_idix_p1,
  output logic [RW-1:0] rd_idix_p1,
  output logic [DW-1:0] imm5_sx_idix_p1,
  output logic [DW-1:0] imm8_sx_idix_p1,
  output logic [DW-1:0] imm11_sx_idix_p1,
  output logic          halt_p1,
  output logic          in_handler_p1
);

  logic          valid_reg;
  logic [DW-1:0] inst_reg, pc_reg, nxt_pc_reg;
  logic          err_reg;
  state_t        state;
  logic          squash, redirect;

  // A slot captured on the edge that raises a pulse, or while squash is pending, is wrong-path.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg  <= 1'b0;
      inst_reg   <= NOP_INST;
      pc_reg     <= '0;
      nxt_pc_reg <= '0;
      err_reg    <= 1'b0;
    end else if (branch_taken_ixif_p1) begin
      valid_reg <= 1'b0;
      inst_reg  <= NOP_INST;
      err_reg   <= 1'b0;
    end else if (!stall_p1) begin
      valid_reg  <= !(squash || redirect);
      inst_reg   <= inst_ifid_p1;
      pc_reg     <= pc_p1;
      nxt_pc_reg <= nxt_pc_p1;
      err_reg    <= err_p1;
    end
  end

  ifid_exc_fsm u_exc_fsm (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (valid_reg),
    .id_opcode     (inst_reg[15:11]),
    .id_err        (err_reg),
    .stall         (stall_p1),
    .branch_taken  (branch_taken_ixif_p1),
    .state         (state),
    .illegal_pulse (illegal_op_idif_p1),
    .return_pulse  (return_execution_idif_p1),
    .squash        (squash),
    .redirect      (redirect)
  );

  assign halt_p1          = (state == ST_HALTED);
  assign in_handler_p1    = (state == ST_EXC);
  assign valid_idix_p1    = valid_reg && !halt_p1;
  assign inst_idix_p1     = inst_reg;
  assign pc_idix_p1       = pc_reg;
  assign nxt_pc_idix_p1   = nxt_pc_reg;
  assign opcode_idix_p1   = inst_reg[15:11];
  assign rs_idix_p1       = inst_reg[10:8];
  assign rt_idix_p1       = inst_reg[7:5];
  assign rd_idix_p1       = inst_reg[4:2];
  assign imm5_sx_idix_p1  = sext(DW'(inst_reg[4:0]), 5);
  assign imm8_sx_idix_p1  = sext(DW'(inst_reg[7:0]), 8);
  assign imm11_sx_idix_p1 = sext(DW'(inst_reg[10:0]), 11);

endmodule

// File: tb/tb_ifid_decode.sv
// Directed scenarios plus randomized traffic for ifid_decode, checked every cycle against a behavioural model.
module tb_ifid_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] inst_in, pc_in, npc_in;
  logic        err_in, stall_in, br_in;

  logic        illegal, ret_pulse, valid, halt, in_handler;
  logic [15:0] inst_o, pc_o, npc_o, imm5, imm8, imm11;
  logic [4:0]  opcode;
  logic [2:0]  rs, rt, rd;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ifid_decode dut (
    .clk                      (clk),
    .rst                      (rst),
    .inst_ifid_p1             (inst_in),
    .pc_p1                    (pc_in),
    .nxt_pc_p1                (npc_in),
    .err_p1                   (err_in),
    .stall_p1                 (stall_in),
    .branch_taken_ixif_p1     (br_in),
    .illegal_op_idif_p1       (illegal),
    .return_execution_idif_p1 (ret_pulse),
    .valid_idix_p1            (valid),
    .inst_idix_p1             (inst_o),
    .pc_idix_p1               (pc_o),
    .nxt_pc_idix_p1           (npc_o),
    .opcode_idix_p1           (opcode),
    .rs_idix_p1               (rs),
    .rt_idix_p1               (rt),
    .rd_idix_p1               (rd),
    .imm5_sx_idix_p1          (imm5),
    .imm8_sx_idix_p1          (imm8),
    .imm11_sx_idix_p1         (imm11),
    .halt_p1                  (halt),
    .in_handler_p1            (in_handler)
  );

  // Model: what the ID slot holds, which mode the core is in (0 run, 1 handler, 2 halted),
  // whether the next fetched slot is wrong-path, and which pulse the last edge produced.
  bit          m_ok = 1'b0;
  bit          m_live, m_err, m_pend, m_ill, m_ret;
  logic [15:0] m_inst, m_pc, m_npc;
  int          m_mode;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic model_step();
    logic [4:0] op;
    bit fault, acts, ill, ret;
    if (rst) begin
      m_ok = 1'b1; m_live = 0; m_err = 0; m_pend = 0; m_ill = 0; m_ret = 0;
      m_inst = 16'h0800; m_pc = 0; m_npc = 0; m_mode = 0;
    end else begin
      op    = m_inst[15:11];
      fault = (op == 5'd2) || m_err;
      acts  = m_live && !stall_in && !br_in;
      ill = 0; ret = 0;
      if (acts && m_mode == 0) begin
        if (fault) begin ill = 1; m_mode = 1; end
        else if (op == 5'd0) m_mode = 2;
      end else if (acts && m_mode == 1) begin
        if (fault || op == 5'd0) m_mode = 2;
        else if (op == 5'd3) begin ret = 1; m_mode = 0; end
      end
      if (br_in) begin
        m_live = 0; m_inst = 16'h0800; m_err = 0;
      end else if (!stall_in) begin
        m_live = !(m_pend || ill || ret);
        m_inst = inst_in; m_pc = pc_in; m_npc = npc_in; m_err = err_in;
      end
      if (ill || ret) m_pend = 1;
      else if (!stall_in && !br_in) m_pend = 0;
      m_ill = ill; m_ret = ret;
    end
  endtask

  always @(negedge clk) begin
    if (m_ok) begin
      chk("illegal", 16'(illegal), 16'(m_ill));
      chk("return", 16'(ret_pulse), 16'(m_ret));
      chk("valid", 16'(valid), 16'(m_live && m_mode != 2));
      chk("halt", 16'(halt), 16'(m_mode == 2));
      chk("in_handler", 16'(in_handler), 16'(m_mode == 1));
      chk("inst", inst_o, m_inst);
      chk("pc", pc_o, m_pc);
      chk("nxt_pc", npc_o, m_npc);
      chk("opcode", 16'(opcode), 16'(m_inst[15:11]));
      chk("rs", 16'(rs), 16'(m_inst[10:8]));
      chk("rt", 16'(rt), 16'(m_inst[7:5]));
      chk("rd", 16'(rd), 16'(m_inst[4:2]));
      chk("imm5", imm5, 16'($signed(m_inst[4:0])));
      chk("imm8", imm8, 16'($signed(m_inst[7:0])));
      chk("imm11", imm11, 16'($signed(m_inst[10:0])));
    end
  end

  task automatic cyc(input logic r, input logic [15:0] i, input logic [15:0] p,
                     input logic s, input logic b, input logic e);
    rst = r; inst_in = i; pc_in = p; npc_in = p + 16'd2;
    stall_in = s; br_in = b; err_in = e;
    @(posedge clk);
    model_step();
    #1;
  endtask

  localparam logic [15:0] NOP  = 16'h0800;
  localparam logic [15:0] SIIC = 16'h1000;
  localparam logic [15:0] RTI  = 16'h1800;

  initial begin
    logic [15:0] pc, ri;
    int r;
    cyc(1, NOP, 0, 0, 0, 0);
    cyc(1, NOP, 0, 0, 0, 0);
    chk("rst_valid", 16'(valid), 16'd0);
    chk("rst_inst", inst_o, 16'h0800);
    chk("rst_pc", pc_o, 16'd0);
    chk("rst_halt", 16'(halt), 16'd0);
    chk("rst_handler", 16'(in_handler), 16'd0);

    cyc(0, NOP, 4, 0, 0, 0);
    chk("t1_valid", 16'(valid), 16'd1);
    chk("t1_pc", pc_o, 16'd4);
    chk("t1_npc", npc_o, 16'd6);

    cyc(0, SIIC, 8, 0, 0, 0);
    chk("t2_nopulse_yet", 16'(illegal), 16'd0);
    cyc(0, NOP, 10, 0, 0, 0);
    chk("t2_pulse", 16'(illegal), 16'd1);
    chk("t2_handler", 16'(in_handler), 16'd1);
    chk("t2_squash", 16'(valid), 16'd0);
    cyc(0, NOP, 12, 0, 0, 0);
    chk("t2_pulse_end", 16'(illegal), 16'd0);
    chk("t2_squash2", 16'(valid), 16'd0);
    cyc(0, 16'h0810, 14, 0, 0, 0);
    chk("sext_valid", 16'(valid), 16'd1);
    chk("sext_imm5", imm5, 16'hFFF0);

    cyc(0, RTI, 16, 0, 0, 0);
    cyc(0, NOP, 18, 0, 0, 0);
    chk("t3_ret", 16'(ret_pulse), 16'd1);
    chk("t3_handler", 16'(in_handler), 16'd0);
    chk("t3_squash", 16'(valid), 16'd0);
    cyc(0, NOP, 20, 0, 0, 0);
    chk("t3_ret_end", 16'(ret_pulse), 16'd0);
    cyc(0, RTI, 22, 0, 0, 0);
    cyc(0, NOP, 24, 0, 0, 0);
    chk("t3_rti_run", 16'(ret_pulse), 16'd0);
    chk("t3_rti_run_valid", 16'(valid), 16'd1);

    cyc(0, SIIC, 26, 0, 0, 0);
    cyc(0, NOP, 28, 0, 1, 0);
    chk("t4_nopulse", 16'(illegal), 16'd0);
    chk("t4_flush", 16'(valid), 16'd0);
    chk("t4_run", 16'(in_handler), 16'd0);

    cyc(0, SIIC, 30, 0, 0, 0);
    repeat (3) begin
      cyc(0, NOP, 32, 1, 0, 0);
      chk("t5_stall_nopulse", 16'(illegal), 16'd0);
      chk("t5_stall_hold", pc_o, 16'd30);
    end
    cyc(0, NOP, 32, 0, 0, 0);
    chk("t5_pulse", 16'(illegal), 16'd1);
    cyc(0, NOP, 34, 0, 0, 0);
    chk("t5_single", 16'(illegal), 16'd0);

    cyc(0, SIIC, 36, 0, 0, 0);
    cyc(0, NOP, 38, 0, 0, 0);
    chk("dbl_halt", 16'(halt), 16'd1);
    chk("dbl_nopulse", 16'(illegal), 16'd0);
    cyc(0, SIIC, 40, 0, 0, 0);
    cyc(0, NOP, 42, 0, 0, 0);
    chk("t6_sticky", 16'(halt), 16'd1);
    chk("t6_ignored", 16'(illegal), 16'd0);
    cyc(1, NOP, 0, 0, 0, 0);
    chk("t6_rst_halt", 16'(halt), 16'd0);
    chk("t6_rst_handler", 16'(in_handler), 16'd0);
    cyc(0, 16'h0000, 44, 0, 0, 0);
    cyc(0, NOP, 46, 0, 0, 0);
    chk("t6_halt", 16'(halt), 16'd1);

    cyc(1, NOP, 0, 0, 0, 0);
    cyc(0, NOP, 50, 0, 0, 1);
    cyc(0, NOP, 52, 0, 0, 0);
    chk("err_pulse", 16'(illegal), 16'd1);
    chk("err_handler", 16'(in_handler), 16'd1);

    cyc(1, NOP, 0, 0, 0, 0);
    pc = 16'd0;
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3)       ri = {5'b00000, 11'($urandom)};
      else if (r < 20) ri = {5'b00010, 11'($urandom)};
      else if (r < 35) ri = {5'b00011, 11'($urandom)};
      else if (r < 55) ri = {5'b00001, 11'($urandom)};
      else             ri = 16'($urandom);
      pc = pc + 16'd2;
      cyc(($urandom_range(0, 59) == 0), ri, pc,
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 15) == 0));
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
